// File: rtl/load_store_unit.sv
// Load/store unit: performs one aligned 32-bit data-memory access per request
// over a req/ack bus, with address overflow/alignment checks and ack timeout.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, is_load, is_store   request from control (sampled only in IDLE)
//   addr, addr_ovf, store_data effective address, ALU overflow, store value
//   busy, done, error          status to control; done/error are 1-cycle pulses
//   err_code                   0 none, 1 misaligned, 2 addr overflow, 3 timeout
//   load_data                  read data, updated only on a successful load
//   mem_req/we/addr/wdata      bus request, held stable until mem_ack
//   mem_ack, mem_rdata         bus completion and read data
module load_store_unit #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic        addr_ovf,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;

  // Exactly one of load/store must be requested; anything else is ignored.
  logic valid_op;
  assign valid_op = is_load ^ is_store;

  // Single registered FSM; done/error pulse in the cycle after DONE/ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      load_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && valid_op) begin
            busy <= 1'b1;
            if (addr_ovf) begin
              state    <= S_ERR;
              err_code <= ERR_OVF;
            end else if (addr[1:0] != 2'b00) begin
              state    <= S_ERR;
              err_code <= ERR_ALIGN;
            end else begin
              state     <= S_REQ;
              err_code  <= ERR_NONE;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= addr;
              mem_wdata <= is_store ? store_data : 32'd0;
              tmo_cnt   <= '0;
            end
          end
        end
        S_REQ: begin
          // An ack on the timeout edge takes precedence over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) load_data <= mem_rdata;
            state <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req  <= 1'b0;
            err_code <= ERR_TMO;
            state    <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TMO_MAX=4): table of directed
// transactions plus hand sequences for late ack, ignored starts and reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, is_store, addr_ovf;
  logic [31:0] addr, store_data;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.TMO_W(8), .TMO_MAX(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .is_store(is_store), .addr(addr), .addr_ovf(addr_ovf),
    .store_data(store_data), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .load_data(load_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic        ovf;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;     // wait cycles before ack; 255 = never ack
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_lat;   // edges after start edge-1 until done/error seen
    int          exp_req;   // cycles mem_req is high
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0; addr_ovf = 1'b0;
    addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},      32'(busy), 0);
    chk({tag, ".done"},      32'(done), 0);
    chk({tag, ".error"},     32'(error), 0);
    chk({tag, ".err_code"},  32'(err_code), 0);
    chk({tag, ".load_data"}, load_data, 0);
    chk({tag, ".mem_req"},   32'(mem_req), 0);
    chk({tag, ".mem_we"},    32'(mem_we), 0);
    chk({tag, ".mem_addr"},  mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // Issue one request and act as the bus slave until done/error or budget.
  task automatic run_txn(input string tag, input vec_t v);
    int n, req_cycles, seen_at;
    logic [31:0] exp_wdata;
    exp_wdata = v.st ? v.sdata : 32'd0;
    n = 0; req_cycles = 0; seen_at = 0;
    start = 1'b1; is_load = v.ld; is_store = v.st; addr_ovf = v.ovf;
    addr = v.addr; store_data = v.sdata;
    while (seen_at == 0 && n < 20) begin
      step();
      n++;
      if (n == 1) begin
        start = 1'b0; is_load = 1'b0; is_store = 1'b0; addr_ovf = 1'b0;
        addr = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF;
        chk({tag, ".busy"}, 32'(busy), 1);
      end
      if (done || error) seen_at = n;
      if (mem_req) begin
        req_cycles++;
        chk({tag, ".mem_we"},    32'(mem_we), 32'(v.st));
        chk({tag, ".mem_addr"},  mem_addr, v.addr);
        chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
      end
      mem_ack   = mem_req && (req_cycles > v.waits);
      mem_rdata = mem_ack ? v.rdata : 32'h5555_5555;
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h5555_5555;
    chk({tag, ".latency"},   32'(seen_at), 32'(v.exp_lat));
    chk({tag, ".done"},      32'(done), 32'(v.exp_done));
    chk({tag, ".error"},     32'(error), 32'(v.exp_err));
    chk({tag, ".busy_end"},  32'(busy), 0);
    chk({tag, ".req_cyc"},   32'(req_cycles), 32'(v.exp_req));
    if (v.exp_err) chk({tag, ".err_code"}, 32'(err_code), 32'(v.exp_code));
    chk({tag, ".load_data"}, load_data, v.exp_ld);
    step();
    chk({tag, ".done_1cyc"},  32'(done), 0);
    chk({tag, ".error_1cyc"}, 32'(error), 0);
    if (v.exp_err) chk({tag, ".err_code_held"}, 32'(err_code), 32'(v.exp_code));
  endtask

  initial begin
    //           ld  st  ovf addr          sdata         rdata         waits done err code lat req exp_ld
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEAD_BEEF, 0,   1'b1, 1'b0, 2'd0, 3, 1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h1234_5678, 32'hAAAA_AAAA, 3,  1'b1, 1'b0, 2'd0, 6, 4, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h6,   32'h0,        32'h1111_1111, 0,   1'b0, 1'b1, 2'd1, 2, 0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h3,   32'h0,        32'h2222_2222, 0,   1'b0, 1'b1, 2'd2, 2, 0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h20,  32'h0,        32'h3333_3333, 255, 1'b0, 1'b1, 2'd3, 6, 4, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h24,  32'h0,        32'hCAFE_F00D, 3,   1'b1, 1'b0, 2'd0, 6, 4, 32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h40,  32'h7777_7777, 32'h4444_4444, 0,  1'b0, 1'b1, 2'd2, 2, 0, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        32'h0BAD_C0DE, 1,   1'b1, 1'b0, 2'd0, 4, 2, 32'h0BAD_C0DE};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Late ack after a timeout is ignored, then a normal load still works.
    run_txn("tmo", '{1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 255,
                     1'b0, 1'b1, 2'd3, 6, 4, 32'h0BAD_C0DE});
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_BBBB;
    step();
    step();
    mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
    chk("late_ack.busy",  32'(busy), 0);
    chk("late_ack.done",  32'(done), 0);
    chk("late_ack.error", 32'(error), 0);
    chk("late_ack.req",   32'(mem_req), 0);
    chk("late_ack.ld",    load_data, 32'h0BAD_C0DE);
    run_txn("after_tmo", '{1'b1, 1'b0, 1'b0, 32'h54, 32'h0, 32'h600D_F00D, 0,
                           1'b1, 1'b0, 2'd0, 3, 1, 32'h600D_F00D});

    // Start with both or neither op bit is ignored.
    start = 1'b1; is_load = 1'b1; is_store = 1'b1; addr = 32'h60;
    step();
    start = 1'b1; is_load = 1'b0; is_store = 1'b0;
    step();
    idle_inputs();
    chk("bad_op.busy", 32'(busy), 0);
    chk("bad_op.req",  32'(mem_req), 0);
    step();
    chk("bad_op.done",  32'(done), 0);
    chk("bad_op.error", 32'(error), 0);

    // Reset during REQ, with a second start while busy beforehand.
    start = 1'b1; is_load = 1'b1; addr = 32'h80;
    step();
    idle_inputs();
    step();
    start = 1'b1; is_store = 1'b1; addr = 32'h90; store_data = 32'h9999_9999;
    step();
    idle_inputs();
    chk("busy_start.req",   32'(mem_req), 1);
    chk("busy_start.we",    32'(mem_we), 0);
    chk("busy_start.addr",  mem_addr, 32'h80);
    chk("busy_start.wdata", mem_wdata, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("mid_reset");
    mem_ack = 1'b1; mem_rdata = 32'hEEEE_EEEE;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
    step();
    chk("post_reset.done",  32'(done), 0);
    chk("post_reset.error", 32'(error), 0);
    chk("post_reset.ld",    load_data, 0);
    run_txn("post_reset_ld", '{1'b1, 1'b0, 1'b0, 32'hC0, 32'h0, 32'h1357_9BDF, 2,
                               1'b1, 1'b0, 2'd0, 5, 3, 32'h1357_9BDF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU: takes the effective address the ALU computes for LWI/SWI/LW/SW and performs one 32-bit data-memory transaction over a req/ack bus.
- Returns load data for writeback, and pulses done or error back to the core control FSM. The control FSM holds the pipeline while busy is high.

Parameters:
- TMO_W, 8, width of the ack-timeout counter.
- TMO_MAX, 200, cycles mem_req may stay high without ack before the transaction aborts; must be 1..2^TMO_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request from control; sampled only in IDLE.
- is_load  input  1  operation is a load (LWI/LW); sampled with start.
- is_store  input  1  operation is a store (SWI/SW); sampled with start.
- addr  input  32  effective address (ALU alu_result); sampled with start.
- addr_ovf  input  1  ALU alu_overflow for the address add; sampled with start.
- store_data  input  32  register value to store; sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  one-cycle pulse on abort; mutually exclusive with done.
- err_code  output  2  cause, valid while error=1 and held until the next start: 0 none, 1 misaligned, 2 address overflow, 3 timeout.
- load_data  output  32  registered read data; updated only on a successful load.
- mem_req  output  1  bus request, held high until ack.
- mem_we  output  1  1 = write; stable while mem_req=1.
- mem_addr  output  32  word address; stable while mem_req=1.
- mem_wdata  output  32  write data; stable while mem_req=1.
- mem_ack  input  1  slave completion; meaningful only while mem_req=1.
- mem_rdata  input  32  read data; valid in the cycle mem_ack=1.

Behaviour:
- Reset values (all outputs registered): busy=0, done=0, error=0, err_code=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Timeout counter=0. State=IDLE.
- Reset is synchronous and overrides everything. Reset asserted mid-transaction: mem_req=0 after that edge. No done or error is generated. A late mem_ack is ignored.
- States: IDLE, REQ, DONE, ERR.
- IDLE: start=1 with exactly one of is_load/is_store set → checks are applied in this priority:
  - addr_ovf=1 → ERR with code 2.
  - addr[1:0]≠0 → ERR with code 1.
  - otherwise → REQ. Register mem_addr=addr, mem_we=is_store, mem_wdata=store_data (0 for loads), set mem_req=1, clear the counter.
- IDLE: start with neither or both of is_load/is_store → ignored; stay in IDLE with no response.
- REQ, mem_ack=1 at an edge → mem_req=0. If the op is a load, load_data=mem_rdata. Go to DONE.
- REQ, mem_ack=0 → counter+1. When the counter reaches TMO_MAX-1 with no ack → mem_req=0, go to ERR with code 3.
- An ack arriving on the same edge the timeout would fire wins: the transaction completes normally.
- DONE: done=1 for exactly one cycle, then IDLE. ERR: error=1 for exactly one cycle, then IDLE.
- busy=1 in REQ, DONE and ERR.
- start while busy is ignored; it is not queued.
- mem_ack while mem_req=0 is ignored.
- Error paths never assert mem_req and never modify load_data.
- Latency, start sampled at edge k:
  - mem_req is high after edge k.
  - A zero-wait slave (ack in the first REQ cycle) gives done after edge k+2. Each wait cycle adds 1.
  - Error checks give error after edge k+1.
- The next start is accepted in the cycle after done/error, since state is IDLE again.

Test Plan:
- Load, zero-wait: start, is_load, addr=0x0000_0010; slave acks in the first req cycle with rdata=0xDEAD_BEEF → mem_req high for 1 cycle, mem_we=0, mem_addr=0x10; done 2 cycles after start; load_data=0xDEAD_BEEF.
- Store with 3 wait states: addr=0x100, store_data=0x1234_5678 → mem_we=1, mem_wdata=0x1234_5678 stable 4 cycles; done after ack; load_data unchanged.
- Misaligned: addr=0x0000_0006, is_load → error 1 cycle after start with err_code=1; mem_req never asserted. Also addr_ovf=1 with addr=0x3 → err_code=2, showing overflow has priority.
- Timeout: TMO_MAX=4, slave never acks → mem_req high exactly 4 cycles, then error with err_code=3. An ack pulsed later is ignored, and the next start works normally.
- Ack on the timeout edge (ack in the 4th req cycle, TMO_MAX=4) → done asserted, error not asserted.
- Reset asserted during REQ, with start re-asserted while busy beforehand → second start ignored; after reset all outputs are 0; a following load completes correctly.
